multdiv_unit: RTL and testbench

Multicycle signed multiply/divide responder for the processor's execute stage. It receives the one-cycle `mult`/`div` start pulses that the instruction decoder raises for ALU-format instructions with ALUop 00110/00111. It latches both 32-bit operands, iterates for a fixed number of cycles, then returns a registered result with a one-cycle ready pulse. It also flags the overflow and divide-by-zero exceptions that the writeback logic steers into rstatus (r30).

---
 rtl/multdiv_if.sv | 25 ++
 rtl/multdiv_unit.sv | 156 +++++++++++++++
 tb/tb_multdiv_unit.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/multdiv_if.sv
// Handshake/data bundle between the execute-stage decoder and multdiv_unit.
//   master: drives operands and the one-cycle ctrl_MULT / ctrl_DIV start pulses.
//   slave : returns data_result, data_exception, the data_resultRDY pulse and busy.
interface multdiv_if #(
    parameter int unsigned WIDTH = 32
);
    logic [WIDTH-1:0] data_operandA;
    logic [WIDTH-1:0] data_operandB;
    logic             ctrl_MULT;
    logic             ctrl_DIV;
    logic [WIDTH-1:0] data_result;
    logic             data_exception;
    logic             data_resultRDY;
    logic             busy;

    modport master (
        output data_operandA, data_operandB, ctrl_MULT, ctrl_DIV,
        input  data_result, data_exception, data_resultRDY, busy
    );

    modport slave (
        input  data_operandA, data_operandB, ctrl_MULT, ctrl_DIV,
        output data_result, data_exception, data_resultRDY, busy
    );
endinterface

// File: rtl/multdiv_unit.sv
// Multicycle signed multiply / divide unit.
//   clock, reset_n : single rising-edge clock, asynchronous active-low reset.
//   bus (slave)    : operands and start pulses in; registered result, exception flag,
//                    one-cycle data_resultRDY pulse and busy out.
// Multiply uses radix-2 Booth, divide uses non-restoring division on magnitudes. Every
// operation takes WIDTH iterations plus one FIX cycle, independent of the data.
module multdiv_unit #(
    parameter int unsigned WIDTH = 32
) (
    input logic      clock,
    input logic      reset_n,
    multdiv_if.slave bus
);
    typedef enum logic [2:0] {StIdle, StMult, StDiv, StFix, StDone} state_e;

    state_e           state_q, state_d;
    logic [5:0]       cnt_q, cnt_d;
    // Booth accumulator / non-restoring partial remainder; one guard bit so that
    // subtracting the most-negative multiplicand cannot overflow.
    logic [WIDTH:0]   a_q, a_d;
    logic [WIDTH-1:0] q_q, q_d;   // multiplier, or dividend magnitude shifting into quotient
    logic [WIDTH-1:0] m_q, m_d;   // multiplicand, or divisor magnitude
    logic             qm1_q, qm1_d;
    logic             div_q, div_d;
    logic             neg_q, neg_d;
    logic             dz_q, dz_d;
    logic             ovf_q, ovf_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             exc_q, exc_d;

    logic             start;
    logic [WIDTH:0]   a_sum;
    logic [WIDTH:0]   r_sh;
    logic [WIDTH:0]   r_new;
    logic [WIDTH:0]   upper;

    assign start = bus.ctrl_MULT | bus.ctrl_DIV;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        a_d      = a_q;
        q_d      = q_q;
        m_d      = m_q;
        qm1_d    = qm1_q;
        div_d    = div_q;
        neg_d    = neg_q;
        dz_d     = dz_q;
        ovf_d    = ovf_q;
        result_d = result_q;
        exc_d    = exc_q;
        a_sum    = a_q;
        r_sh     = '0;
        r_new    = '0;
        upper    = {a_q[WIDTH-1:0], q_q[WIDTH-1]};

        if (start) begin
            // A start always wins: it also aborts any operation in flight.
            cnt_d = '0;
            a_d   = '0;
            qm1_d = 1'b0;
            if (bus.ctrl_MULT) begin
                state_d = StMult;
                div_d   = 1'b0;
                m_d     = bus.data_operandA;
                q_d     = bus.data_operandB;
            end else begin
                state_d = StDiv;
                div_d   = 1'b1;
                q_d     = bus.data_operandA[WIDTH-1] ? -bus.data_operandA : bus.data_operandA;
                m_d     = bus.data_operandB[WIDTH-1] ? -bus.data_operandB : bus.data_operandB;
                neg_d   = bus.data_operandA[WIDTH-1] ^ bus.data_operandB[WIDTH-1];
                dz_d    = (bus.data_operandB == '0);
                ovf_d   = (bus.data_operandA == {1'b1, {(WIDTH-1){1'b0}}}) &&
                          (bus.data_operandB == '1);
            end
        end else begin
            unique case (state_q)
                StMult: begin
                    case ({q_q[0], qm1_q})
                        2'b01:   a_sum = a_q + {m_q[WIDTH-1], m_q};
                        2'b10:   a_sum = a_q - {m_q[WIDTH-1], m_q};
                        default: a_sum = a_q;
                    endcase
                    a_d   = {a_sum[WIDTH], a_sum[WIDTH:1]};
                    q_d   = {a_sum[0], q_q[WIDTH-1:1]};
                    qm1_d = q_q[0];
                    cnt_d = cnt_q + 6'd1;
                    if (cnt_q == 6'(WIDTH-1)) state_d = StFix;
                end
                StDiv: begin
                    r_sh  = {a_q[WIDTH-1:0], q_q[WIDTH-1]};
                    // Remainder sign before the shift picks add (restore) or subtract.
                    r_new = a_q[WIDTH] ? r_sh + {1'b0, m_q} : r_sh - {1'b0, m_q};
                    a_d   = r_new;
                    q_d   = {q_q[WIDTH-2:0], ~r_new[WIDTH]};
                    cnt_d = cnt_q + 6'd1;
                    if (cnt_q == 6'(WIDTH-1)) state_d = StFix;
                end
                StFix: begin
                    if (!div_q) begin
                        result_d = q_q;
                        exc_d    = ~((&upper) | ~(|upper));
                    end else if (dz_q) begin
                        result_d = '0;
                        exc_d    = 1'b1;
                    end else if (ovf_q) begin
                        result_d = {1'b1, {(WIDTH-1){1'b0}}};
                        exc_d    = 1'b1;
                    end else begin
                        result_d = neg_q ? -q_q : q_q;
                        exc_d    = 1'b0;
                    end
                    state_d = StDone;
                end
                StDone:  state_d = StIdle;
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            a_q      <= '0;
            q_q      <= '0;
            m_q      <= '0;
            qm1_q    <= 1'b0;
            div_q    <= 1'b0;
            neg_q    <= 1'b0;
            dz_q     <= 1'b0;
            ovf_q    <= 1'b0;
            result_q <= '0;
            exc_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            a_q      <= a_d;
            q_q      <= q_d;
            m_q      <= m_d;
            qm1_q    <= qm1_d;
            div_q    <= div_d;
            neg_q    <= neg_d;
            dz_q     <= dz_d;
            ovf_q    <= ovf_d;
            result_q <= result_d;
            exc_q    <= exc_d;
        end
    end

    assign bus.data_result    = result_q;
    assign bus.data_exception = exc_q;
    assign bus.data_resultRDY = (state_q == StDone);
    assign bus.busy           = (state_q == StMult) || (state_q == StDiv) || (state_q == StFix);
endmodule

// File: tb/tb_multdiv_unit.sv
// Directed bench for multdiv_unit: reset, multiply, divide, exceptions, abort and
// back-to-back starts, all against hand-computed results.
module tb_multdiv_unit;
    logic clock;
    logic reset_n;
    int   checks;
    int   failures;
    int   n;
    int   rdy_seen;

    multdiv_if #(.WIDTH(32)) bus ();

    multdiv_unit #(.WIDTH(32)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge: the next rising edge is the start edge E0. Returns at the
    // negedge after E0 with operands scrambled to show they are not re-sampled.
    task automatic drive_start(input logic m, input logic d, input logic [31:0] a,
                               input logic [31:0] b);
        bus.ctrl_MULT     = m;
        bus.ctrl_DIV      = d;
        bus.data_operandA = a;
        bus.data_operandB = b;
        @(negedge clock);
        bus.ctrl_MULT     = 1'b0;
        bus.ctrl_DIV      = 1'b0;
        bus.data_operandA = $urandom;
        bus.data_operandB = $urandom;
    endtask

    task automatic issue(input logic m, input logic d, input logic [31:0] a,
                         input logic [31:0] b);
        @(negedge clock);
        drive_start(m, d, a, b);
    endtask

    // Cycles from E0 to the first negedge that sees data_resultRDY; -1 on timeout.
    task automatic wait_rdy(output int cycles);
        cycles = -1;
        for (int i = 1; i <= 50; i++) begin
            @(negedge clock);
            if (bus.data_resultRDY) begin
                cycles = i;
                break;
            end
        end
    endtask

    task automatic run_op(input string tag, input logic m, input logic d, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_res,
                          input logic exp_exc);
        int c;
        issue(m, d, a, b);
        wait_rdy(c);
        check({tag, "_latency"}, 64'(c), 64'd33);
        check({tag, "_result"}, 64'(bus.data_result), 64'(exp_res));
        check({tag, "_exc"}, 64'(bus.data_exception), 64'(exp_exc));
    endtask

    initial begin
        checks            = 0;
        failures          = 0;
        reset_n           = 1'b0;
        bus.ctrl_MULT     = 1'b0;
        bus.ctrl_DIV      = 1'b0;
        bus.data_operandA = '0;
        bus.data_operandB = '0;
        repeat (3) @(negedge clock);
        check("reset_result", 64'(bus.data_result), 64'd0);
        check("reset_rdy", 64'(bus.data_resultRDY), 64'd0);
        check("reset_busy", 64'(bus.busy), 64'd0);
        reset_n = 1'b1;

        // Basic multiply with pulse width and busy checks.
        issue(1'b1, 1'b0, 32'd7, 32'hFFFF_FFFA);
        check("mul_busy_start", 64'(bus.busy), 64'd1);
        wait_rdy(n);
        check("mul_latency", 64'(n), 64'd33);
        check("mul_result", 64'(bus.data_result), 64'hFFFF_FFD6);
        check("mul_exc", 64'(bus.data_exception), 64'd0);
        check("mul_busy_done", 64'(bus.busy), 64'd0);
        @(negedge clock);
        check("mul_rdy_width", 64'(bus.data_resultRDY), 64'd0);
        check("mul_result_held", 64'(bus.data_result), 64'hFFFF_FFD6);

        // Asynchronous reset at iteration 10 of a multiply.
        issue(1'b1, 1'b0, 32'd3, 32'd3);
        repeat (10) @(negedge clock);
        check("rst_busy_before", 64'(bus.busy), 64'd1);
        #2 reset_n = 1'b0;
        #1;
        check("rst_async_result", 64'(bus.data_result), 64'd0);
        check("rst_async_exc", 64'(bus.data_exception), 64'd0);
        check("rst_async_busy", 64'(bus.busy), 64'd0);
        check("rst_async_rdy", 64'(bus.data_resultRDY), 64'd0);
        @(negedge clock);
        reset_n  = 1'b1;
        rdy_seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (bus.data_resultRDY || bus.busy) rdy_seen++;
        end
        check("rst_stays_idle", 64'(rdy_seen), 64'd0);

        run_op("mul_ovf", 1'b1, 1'b0, 32'h0001_0000, 32'h0001_0000, 32'h0, 1'b1);
        run_op("mul_minneg", 1'b1, 1'b0, 32'h8000_0000, 32'h1, 32'h8000_0000, 1'b0);
        run_op("mul_negneg", 1'b1, 1'b0, 32'hFFFF_FFFD, 32'hFFFF_FFFB, 32'd15, 1'b0);
        run_op("div_m7_2", 1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b0);
        run_op("div_100_m10", 1'b0, 1'b1, 32'd100, 32'hFFFF_FFF6, 32'hFFFF_FFF6, 1'b0);
        run_op("div_by_zero", 1'b0, 1'b1, 32'd5, 32'd0, 32'd0, 1'b1);
        run_op("div_ovf", 1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1);
        run_op("div_1000_7", 1'b0, 1'b1, 32'd1000, 32'd7, 32'd142, 1'b0);

        // Abort a divide at iteration 5 with a multiply.
        issue(1'b0, 1'b1, 32'd9, 32'd3);
        repeat (4) @(negedge clock);
        drive_start(1'b1, 1'b0, 32'd3, 32'd4);
        wait_rdy(n);
        check("abort_latency", 64'(n), 64'd33);
        check("abort_result", 64'(bus.data_result), 64'd12);
        check("abort_exc", 64'(bus.data_exception), 64'd0);

        // Back-to-back: next multiply requested during the DONE cycle.
        issue(1'b1, 1'b0, 32'd2, 32'd5);
        wait_rdy(n);
        check("b2b_first_latency", 64'(n), 64'd33);
        check("b2b_first_result", 64'(bus.data_result), 64'd10);
        drive_start(1'b1, 1'b0, 32'd11, 32'd3);
        wait_rdy(n);
        check("b2b_second_latency", 64'(n), 64'd33);
        check("b2b_second_result", 64'(bus.data_result), 64'd33);

        // Both start strobes: multiply wins.
        run_op("both_strobes", 1'b1, 1'b1, 32'd6, 32'd3, 32'd18, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
